mef_encaixotamento: RTL and testbench
=====================================

MEF_ENCAIXOTAMENTO -- requirements
Module: mef_encaixotamento

Interface
REQ-001 Parameter DUZIA, default 12: bottles per box.
REQ-002 Parameter FILA_MAX, default 7: bottle buffer capacity, range 1..15.
REQ-003 Parameter TIMEOUT, default 255: max cycles in PEGA before fault, range 1..255.
REQ-004 CLK  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-006 conta  input  1  one-cycle pulse; one approved bottle enters buffer (driven by quality-control stage).
REQ-007 caixa  input  1  level; empty/partial box in packing position.
REQ-008 garraOk  input  1  level; gripper reports bottle placed.
REQ-009 limpa  input  1  one-cycle pulse; clears faults and sticky alarms.
REQ-010 garra  output  1  gripper command.
REQ-011 esteiraCaixa  output  1  box conveyor motor.
REQ-012 fila  output  4  bottles waiting in buffer.
REQ-013 noCaixa  output  4  bottles in current box.
REQ-014 caixas  output  8  completed boxes, binary.
REQ-015 cheioFila  output  1  buffer full; upstream stops feeding.
REQ-016 alarmeFila  output  1  sticky; bottle lost on full buffer.
REQ-017 alarmeGarra  output  1  gripper timeout or box lost.

Function
REQ-018 All outputs registered; each output changes only on CLK rising edge or reset assertion.
REQ-019 States: ESPERA, PRONTO, PEGA, TROCA, ERRO; encoding is free.
REQ-020 ESPERA: esteiraCaixa=1, garra=0. When caixa=1, next state is PRONTO and esteiraCaixa=0.
REQ-021 PRONTO: caixa=0 goes to ERRO. Otherwise, fila>0 goes to PEGA with garra=1 on the same edge and timer=0.
REQ-022 PEGA: garra=1 and timer increments each cycle.
REQ-023 PEGA with garraOk=1:
  - garra=0, fila decrements, noCaixa increments.
  - If new noCaixa==DUZIA, next state is TROCA; else PRONTO.
REQ-024 PEGA with caixa=0, or timer reaching TIMEOUT with garraOk=0: next state is ERRO. garraOk takes priority over timeout on the same cycle.
REQ-025 Entry to TROCA: noCaixa=0, caixas increments (255 wraps to 0), esteiraCaixa=1.
REQ-026 TROCA: when caixa=0, next state is ESPERA and esteiraCaixa stays 1.
REQ-027 ERRO: garra=0, esteiraCaixa=0, alarmeGarra=1. On limpa, next state is ESPERA and alarmeGarra=0. fila and noCaixa are held.
REQ-028 fila increments on conta when fila<FILA_MAX.
REQ-029 Simultaneous conta and decrement: fila unchanged, no alarm, including when fila==FILA_MAX.
REQ-030 conta with fila==FILA_MAX and no decrement: bottle dropped, alarmeFila=1 until limpa or reset.
REQ-031 cheioFila=1 exactly when registered fila==FILA_MAX.
REQ-032 conta and all FIFO accounting stay active in every state, including ERRO.
REQ-033 limpa outside ERRO clears only alarmeFila.
REQ-034 limpa together with a new fill-overflow event: set wins (alarmeFila=1).

Reset
REQ-035 reset=0 gives:
  - state ESPERA;
  - fila=0, noCaixa=0, caixas=0, timer=0;
  - garra=0, esteiraCaixa=0, cheioFila=0, alarmeFila=0, alarmeGarra=0.
REQ-036 First edge after reset release applies ESPERA outputs (esteiraCaixa=1 if caixa=0).
REQ-037 Reset mid-PEGA drops garra immediately. Buffered and boxed counts are discarded.

Verification
REQ-038 Reset, caixa=1, 12 conta pulses, garraOk answered 3 cycles after each garra rise -> 12 garra cycles; noCaixa 0; caixas=1; state TROCA with esteiraCaixa=1 until caixa=0.
REQ-039 caixa=1, gripper idle (garraOk=0), 8 conta pulses -> fila=7, cheioFila=1 after 7th; 8th sets alarmeFila=1, fila stays 7.
REQ-040 fila==7, conta coincident with garraOk acceptance -> fila=7, alarmeFila=0.
REQ-041 garraOk held 0 in PEGA -> ERRO after TIMEOUT cycles; alarmeGarra=1, garra=0; limpa -> ESPERA, alarmeGarra=0, fila unchanged.
REQ-042 caixa dropped to 0 during PEGA -> ERRO next edge, garra=0. reset asserted there -> all outputs 0 asynchronously.
REQ-043 256 full boxes -> caixas wraps to 0.

Source files
------------

// File: rtl/mef_encaixotamento.sv
// Bottle boxing controller: buffers approved bottles, drives the gripper
// that places them into boxes of DUZIA bottles, and handles box changes,
// gripper timeout and buffer-overflow alarms.
module mef_encaixotamento #(
    parameter int DUZIA    = 12,
    parameter int FILA_MAX = 7,
    parameter int TIMEOUT  = 255
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       conta,
    input  logic       caixa,
    input  logic       garraOk,
    input  logic       limpa,
    output logic       garra,
    output logic       esteiraCaixa,
    output logic [3:0] fila,
    output logic [3:0] noCaixa,
    output logic [7:0] caixas,
    output logic       cheioFila,
    output logic       alarmeFila,
    output logic       alarmeGarra
);

    localparam logic [3:0] DUZIA_L    = 4'(DUZIA);
    localparam logic [3:0] FILA_MAX_L = 4'(FILA_MAX);
    // Last timer value still allowed in PEGA; the next edge without
    // garraOk completes TIMEOUT cycles and moves to ERRO.
    localparam logic [7:0] TIMER_FIM  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ESPERA,
        PRONTO,
        PEGA,
        TROCA,
        ERRO
    } estado_t;

    estado_t    estado_q, estado_d;
    logic       garra_q, garra_d;
    logic       esteira_q, esteira_d;
    logic [3:0] fila_q, fila_d;
    logic [3:0] nocaixa_q, nocaixa_d;
    logic [7:0] caixas_q, caixas_d;
    logic       cheio_q, cheio_d;
    logic       alfila_q, alfila_d;
    logic       algarra_q, algarra_d;
    logic [7:0] timer_q, timer_d;
    logic       aceita;
    logic       descarte;

    // State and all output registers; reset discards buffered and boxed counts.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            estado_q  <= ESPERA;
            garra_q   <= 1'b0;
            esteira_q <= 1'b0;
            fila_q    <= 4'd0;
            nocaixa_q <= 4'd0;
            caixas_q  <= 8'd0;
            cheio_q   <= 1'b0;
            alfila_q  <= 1'b0;
            algarra_q <= 1'b0;
            timer_q   <= 8'd0;
        end else begin
            estado_q  <= estado_d;
            garra_q   <= garra_d;
            esteira_q <= esteira_d;
            fila_q    <= fila_d;
            nocaixa_q <= nocaixa_d;
            caixas_q  <= caixas_d;
            cheio_q   <= cheio_d;
            alfila_q  <= alfila_d;
            algarra_q <= algarra_d;
            timer_q   <= timer_d;
        end
    end

    // Next state plus the registered values of gripper, conveyor, box counters.
    always_comb begin
        estado_d  = estado_q;
        garra_d   = 1'b0;
        esteira_d = esteira_q;
        algarra_d = algarra_q;
        timer_d   = 8'd0;
        nocaixa_d = nocaixa_q;
        caixas_d  = caixas_q;
        aceita    = 1'b0;
        case (estado_q)
            ESPERA: begin
                esteira_d = 1'b1;
                if (caixa) begin
                    estado_d  = PRONTO;
                    esteira_d = 1'b0;
                end
            end
            PRONTO: begin
                esteira_d = 1'b0;
                if (!caixa) begin
                    estado_d  = ERRO;
                    algarra_d = 1'b1;
                end else if (fila_q != 4'd0) begin
                    estado_d = PEGA;
                    garra_d  = 1'b1;
                end
            end
            PEGA: begin
                esteira_d = 1'b0;
                garra_d   = 1'b1;
                timer_d   = timer_q + 8'd1;
                // A lost box outranks a placement report: the bottle is not
                // counted into a box that is no longer there.
                if (!caixa) begin
                    estado_d  = ERRO;
                    garra_d   = 1'b0;
                    algarra_d = 1'b1;
                end else if (garraOk) begin
                    aceita  = 1'b1;
                    garra_d = 1'b0;
                    if (nocaixa_q + 4'd1 == DUZIA_L) begin
                        estado_d  = TROCA;
                        nocaixa_d = 4'd0;
                        caixas_d  = caixas_q + 8'd1;
                        esteira_d = 1'b1;
                    end else begin
                        estado_d  = PRONTO;
                        nocaixa_d = nocaixa_q + 4'd1;
                    end
                end else if (timer_q == TIMER_FIM) begin
                    estado_d  = ERRO;
                    garra_d   = 1'b0;
                    algarra_d = 1'b1;
                end
            end
            TROCA: begin
                esteira_d = 1'b1;
                if (!caixa) begin
                    estado_d = ESPERA;
                end
            end
            ERRO: begin
                esteira_d = 1'b0;
                algarra_d = 1'b1;
                if (limpa) begin
                    estado_d  = ESPERA;
                    algarra_d = 1'b0;
                    esteira_d = 1'b1;
                end
            end
            default: begin
                estado_d  = ESPERA;
                esteira_d = 1'b0;
            end
        endcase
    end

    // Buffer accounting, active in every state; overflow alarm set beats clear.
    always_comb begin
        fila_d   = fila_q;
        alfila_d = alfila_q;
        descarte = 1'b0;
        if (conta && !aceita) begin
            if (fila_q < FILA_MAX_L) begin
                fila_d = fila_q + 4'd1;
            end else begin
                descarte = 1'b1;
            end
        end else if (!conta && aceita) begin
            fila_d = fila_q - 4'd1;
        end
        if (descarte) begin
            alfila_d = 1'b1;
        end else if (limpa) begin
            alfila_d = 1'b0;
        end
        cheio_d = (fila_d == FILA_MAX_L);
    end

    assign garra        = garra_q;
    assign esteiraCaixa = esteira_q;
    assign fila         = fila_q;
    assign noCaixa      = nocaixa_q;
    assign caixas       = caixas_q;
    assign cheioFila    = cheio_q;
    assign alarmeFila   = alfila_q;
    assign alarmeGarra  = algarra_q;

endmodule

// File: tb/tb_mef_encaixotamento.sv
// Directed bench for mef_encaixotamento with default parameters.
module tb_mef_encaixotamento;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       conta = 1'b0;
    logic       caixa = 1'b0;
    logic       garraOk = 1'b0;
    logic       limpa = 1'b0;
    logic       garra;
    logic       esteiraCaixa;
    logic [3:0] fila;
    logic [3:0] noCaixa;
    logic [7:0] caixas;
    logic       cheioFila;
    logic       alarmeFila;
    logic       alarmeGarra;

    int total = 0;
    int bad   = 0;
    int n;
    int ng;

    mef_encaixotamento dut (
        .CLK          (CLK),
        .reset        (reset),
        .conta        (conta),
        .caixa        (caixa),
        .garraOk      (garraOk),
        .limpa        (limpa),
        .garra        (garra),
        .esteiraCaixa (esteiraCaixa),
        .fila         (fila),
        .noCaixa      (noCaixa),
        .caixas       (caixas),
        .cheioFila    (cheioFila),
        .alarmeFila   (alarmeFila),
        .alarmeGarra  (alarmeGarra)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_garra"}, garra, 0);
        check({tag, "_esteira"}, esteiraCaixa, 0);
        check({tag, "_fila"}, fila, 0);
        check({tag, "_noCaixa"}, noCaixa, 0);
        check({tag, "_caixas"}, caixas, 0);
        check({tag, "_cheio"}, cheioFila, 0);
        check({tag, "_alFila"}, alarmeFila, 0);
        check({tag, "_alGarra"}, alarmeGarra, 0);
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick();
        check("espera_esteira", esteiraCaixa, 1);
        check("espera_garra", garra, 0);
        caixa = 1'b1;
        tick();
        check("pronto_esteira", esteiraCaixa, 0);

        // one full box, gripper answering 3 cycles after each garra rise
        ng = 0;
        for (int i = 1; i <= 12; i++) begin
            conta = 1'b1;
            tick();
            conta = 1'b0;
            check("box_fila_in", fila, 1);
            tick();
            check("box_garra_up", garra, 1);
            if (garra === 1'b1) ng++;
            tick();
            tick();
            garraOk = 1'b1;
            tick();
            garraOk = 1'b0;
            check("box_garra_down", garra, 0);
            check("box_noCaixa", noCaixa, i % 12);
            check("box_fila_out", fila, 0);
        end
        check("box_garra_cycles", ng, 12);
        check("box_caixas", caixas, 1);
        check("troca_esteira", esteiraCaixa, 1);
        repeat (3) tick();
        check("troca_hold_esteira", esteiraCaixa, 1);
        check("troca_hold_garra", garra, 0);
        caixa = 1'b0;
        tick();
        check("troca_espera_esteira", esteiraCaixa, 1);
        check("troca_espera_caixas", caixas, 1);

        // buffer fill with idle gripper, 8 bottles into capacity 7
        caixa = 1'b1;
        tick();
        conta = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) begin
                check("fill7_fila", fila, 7);
                check("fill7_cheio", cheioFila, 1);
                check("fill7_alFila", alarmeFila, 0);
            end
            if (k == 8) begin
                check("fill8_fila", fila, 7);
                check("fill8_alFila", alarmeFila, 1);
                check("fill8_cheio", cheioFila, 1);
            end
        end
        conta = 1'b0;
        check("fill_pega_garra", garra, 1);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        check("limpa_pega_alFila", alarmeFila, 0);
        check("limpa_pega_alGarra", alarmeGarra, 0);
        check("limpa_pega_garra", garra, 1);

        // conta coincident with accepted placement on a full buffer
        conta = 1'b1;
        garraOk = 1'b1;
        tick();
        conta = 1'b0;
        garraOk = 1'b0;
        check("coinc_fila", fila, 7);
        check("coinc_alFila", alarmeFila, 0);
        check("coinc_noCaixa", noCaixa, 1);
        check("coinc_garra", garra, 0);
        check("coinc_cheio", cheioFila, 1);

        // gripper timeout
        tick();
        n = 0;
        while (garra === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        check("timeout_cycles", n, 255);
        check("erro_alGarra", alarmeGarra, 1);
        check("erro_garra", garra, 0);
        check("erro_esteira", esteiraCaixa, 0);
        check("erro_fila", fila, 7);
        conta = 1'b1;
        tick();
        conta = 1'b0;
        check("erro_drop_alFila", alarmeFila, 1);
        check("erro_drop_fila", fila, 7);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        check("limpa_erro_alGarra", alarmeGarra, 0);
        check("limpa_erro_alFila", alarmeFila, 0);
        check("limpa_erro_esteira", esteiraCaixa, 1);
        check("limpa_erro_fila", fila, 7);
        check("limpa_erro_noCaixa", noCaixa, 1);
        tick();
        check("repronto_esteira", esteiraCaixa, 0);

        // limpa together with a new overflow: set wins
        conta = 1'b1;
        limpa = 1'b1;
        tick();
        conta = 1'b0;
        limpa = 1'b0;
        check("setwins_alFila", alarmeFila, 1);
        check("setwins_garra", garra, 1);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        check("clear_alFila", alarmeFila, 0);

        // box lost during PEGA, then asynchronous reset in ERRO
        caixa = 1'b0;
        tick();
        check("boxlost_garra", garra, 0);
        check("boxlost_alGarra", alarmeGarra, 1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_rst_erro");
        repeat (2) tick();
        reset = 1'b1;

        // asynchronous reset mid-PEGA drops the gripper at once
        caixa = 1'b1;
        conta = 1'b1;
        tick();
        conta = 1'b0;
        tick();
        check("midpega_garra_up", garra, 1);
        #2 reset = 1'b0;
        #1;
        check("midpega_garra_rst", garra, 0);
        check("midpega_fila_rst", fila, 0);
        tick();
        reset = 1'b1;
        caixa = 1'b0;
        tick();

        // 256 full boxes wrap the box counter
        for (int b = 1; b <= 256; b++) begin
            caixa = 1'b1;
            garraOk = 1'b1;
            conta = 1'b1;
            repeat (12) tick();
            conta = 1'b0;
            n = 0;
            while (esteiraCaixa !== 1'b1 && n < 100) begin
                n++;
                tick();
            end
            check("wrap_caixas", caixas, b % 256);
            check("wrap_noCaixa", noCaixa, 0);
            caixa = 1'b0;
            garraOk = 1'b0;
            tick();
        end
        check("wrap_final_fila", fila, 0);
        check("wrap_final_alFila", alarmeFila, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
